// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module  : piso_tx
// Brief   : Parallel-in/serial-out transmitter with valid/ready load and
//           per-bit clock divider; strobe marks the receiver sample cycle.
// Revision: 1.0
// ============================================================================
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int BIT_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_strobe,
    output logic             busy,
    output logic             done
);

    localparam int c_BW = $clog2(WIDTH);
    localparam int c_DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(BIT_DIV - 1);
    localparam logic            c_STROBE_EVERY = (BIT_DIV == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [c_DW-1:0]   r_div_cnt;

    logic [WIDTH-1:0]  w_shifted;
    logic              w_next_out;
    logic              w_first_out;
    logic              w_div_last;
    logic [c_DW-1:0]   w_div_inc;

    // ser_out is registered, so the bit for the next period is taken from
    // the word as it will look after the shift.
    always_comb begin
        w_shifted   = '0;
        w_next_out  = 1'b0;
        w_first_out = 1'b0;
        if (MSB_FIRST != 0) begin
            w_shifted   = {r_shreg[WIDTH-2:0], 1'b0};
            w_next_out  = r_shreg[WIDTH-2];
            w_first_out = load_data[WIDTH-1];
        end else begin
            w_shifted   = {1'b0, r_shreg[WIDTH-1:1]};
            w_next_out  = r_shreg[1];
            w_first_out = load_data[0];
        end
    end

    assign w_div_last = (r_div_cnt == c_DIV_LAST);
    assign w_div_inc  = r_div_cnt + c_DW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            load_ready <= 1'b1;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            ser_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_valid && load_ready) begin
                        r_shreg    <= load_data;
                        r_bit_cnt  <= c_BIT_LAST;
                        r_div_cnt  <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        ser_valid  <= 1'b1;
                        ser_out    <= w_first_out;
                        ser_strobe <= c_STROBE_EVERY;
                        r_state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            r_shreg    <= w_shifted;
                            r_bit_cnt  <= r_bit_cnt - c_BW'(1);
                            ser_out    <= w_next_out;
                            ser_strobe <= c_STROBE_EVERY;
                        end else begin
                            ser_out    <= 1'b0;
                            ser_valid  <= 1'b0;
                            ser_strobe <= 1'b0;
                            done       <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        r_div_cnt  <= w_div_inc;
                        ser_strobe <= (w_div_inc == c_DIV_LAST);
                    end
                end

                S_DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: begin
                    ser_out    <= 1'b0;
                    ser_valid  <= 1'b0;
                    ser_strobe <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_tx
// Brief   : Directed, table-driven bench for piso_tx across several divider
//           and bit-order configurations, plus hold and mid-frame reset cases.
// Revision: 1.0
// ============================================================================
module tb_piso_tx;

    localparam int N_DUT = 5;
    localparam int DIVS [N_DUT] = '{1, 4, 1, 2, 3};
    localparam int MSBF [N_DUT] = '{1, 1, 0, 1, 1};

    logic       clk;
    logic       reset;
    logic       lv [N_DUT];
    logic [7:0] ld [N_DUT];
    logic       lr [N_DUT];
    logic       so [N_DUT];
    logic       sv [N_DUT];
    logic       ss [N_DUT];
    logic       by [N_DUT];
    logic       dn [N_DUT];
    logic [7:0] q;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        piso_tx #(
            .WIDTH    (8),
            .BIT_DIV  (DIVS[g]),
            .MSB_FIRST(MSBF[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .load_valid(lv[g]),
            .load_data (ld[g]),
            .load_ready(lr[g]),
            .ser_out   (so[g]),
            .ser_valid (sv[g]),
            .ser_strobe(ss[g]),
            .busy      (by[g]),
            .done      (dn[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback receiver on the BIT_DIV=4 instance.
    always @(posedge clk) if (ss[1] === 1'b1) q <= {q[6:0], so[1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends one word on instance idx and checks every cycle of the frame
    // against the bit sequence exp (first transmitted bit in exp[7]).
    task automatic run_frame(input int idx, input logic [7:0] data, input logic [7:0] exp,
                             input bit hold, input logic [7:0] nxt);
        int d;
        int nstb;
        int waited;
        logic bitv;
        d = DIVS[idx];
        waited = 0;
        while (lr[idx] !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (lr[idx] !== 1'b1) begin
            chk("ready_timeout", 32'(lr[idx]), 32'd1);
            return;
        end
        lv[idx] = 1'b1;
        ld[idx] = data;
        @(posedge clk); #1;
        if (!hold) lv[idx] = 1'b0;
        ld[idx] = hold ? nxt : ~data;
        nstb = 0;
        for (int c = 1; c <= 8*d + 2; c++) begin
            if (c <= 8*d) begin
                bitv = exp[7 - (c-1)/d];
                chk("ser_out",    32'(so[idx]), 32'(bitv));
                chk("ser_valid",  32'(sv[idx]), 32'd1);
                chk("ser_strobe", 32'(ss[idx]), 32'(((c-1) % d) == d-1));
                chk("busy",       32'(by[idx]), 32'd1);
                chk("load_ready", 32'(lr[idx]), 32'd0);
                chk("done_early", 32'(dn[idx]), 32'd0);
            end else if (c == 8*d + 1) begin
                chk("done",        32'(dn[idx]), 32'd1);
                chk("busy_done",   32'(by[idx]), 32'd1);
                chk("valid_done",  32'(sv[idx]), 32'd0);
                chk("out_done",    32'(so[idx]), 32'd0);
                chk("ready_done",  32'(lr[idx]), 32'd0);
                chk("strobe_done", 32'(ss[idx]), 32'd0);
                chk("strobe_count", 32'(nstb), 32'd8);
                if (idx == 1) chk("loopback_q", 32'(q), 32'(data));
            end else begin
                chk("ready_back", 32'(lr[idx]), 32'd1);
                chk("busy_idle",  32'(by[idx]), 32'd0);
                chk("done_clear", 32'(dn[idx]), 32'd0);
                chk("valid_idle", 32'(sv[idx]), 32'd0);
            end
            if (ss[idx] === 1'b1) nstb++;
            if (c < 8*d + 2) begin
                @(posedge clk); #1;
            end
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{0, 8'hA5, 8'b1010_0101};
        tbl[1] = '{0, 8'h5A, 8'b0101_1010};
        tbl[2] = '{1, 8'h3C, 8'b0011_1100};
        tbl[3] = '{2, 8'h01, 8'b1000_0000};
        tbl[4] = '{2, 8'hB4, 8'b0010_1101};
        tbl[5] = '{4, 8'h80, 8'b1000_0000};
        tbl[6] = '{3, 8'h81, 8'b1000_0001};

        reset = 1'b0;
        for (int i = 0; i < N_DUT; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            chk("rst_ready",  32'(lr[i]), 32'd1);
            chk("rst_out",    32'(so[i]), 32'd0);
            chk("rst_valid",  32'(sv[i]), 32'd0);
            chk("rst_strobe", 32'(ss[i]), 32'd0);
            chk("rst_busy",   32'(by[i]), 32'd0);
            chk("rst_done",   32'(dn[i]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++)
            run_frame(tbl[v].idx, tbl[v].data, tbl[v].exp, 1'b0, 8'h00);

        // load_valid held across the frame while the data changes underneath
        run_frame(0, 8'hFF, 8'hFF, 1'b1, 8'h00);
        run_frame(0, 8'h00, 8'h00, 1'b0, 8'h00);

        // Reset in the middle of bit 3 of 8'hC3 on the BIT_DIV=2 instance
        repeat (2) @(posedge clk);
        #1;
        lv[3] = 1'b1;
        ld[3] = 8'hC3;
        @(posedge clk); #1;
        lv[3] = 1'b0;
        ld[3] = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(sv[3]), 32'd1);
        chk("pre_rst_out",   32'(so[3]), 32'd0);
        chk("pre_rst_busy",  32'(by[3]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(sv[3]), 32'd0);
        chk("async_out",   32'(so[3]), 32'd0);
        chk("async_ready", 32'(lr[3]), 32'd1);
        chk("async_busy",  32'(by[3]), 32'd0);
        chk("async_done",  32'(dn[3]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("no_done_after_rst",  32'(dn[3]), 32'd0);
            chk("no_valid_after_rst", 32'(sv[3]), 32'd0);
            @(posedge clk); #1;
        end
        run_frame(3, 8'h81, 8'b1000_0001, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
